// File: rtl/fwd_scoreboard_unit.sv
// Forwarding / hazard unit for the 5-stage pipeline.
// Keeps a DEPTH-entry shift scoreboard of in-flight register writers, resolves
// NUM_SRC source operands of the instruction in ID, and produces registered
// EX-stage forward selects plus a combinational stall with run-length tracking.
module fwd_scoreboard_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SEL_W       = $clog2(DEPTH),
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned STALL_LIMIT = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_wr_en,
  input  logic [REG_AW-1:0]         issue_wr_addr,
  input  logic [SEL_W-1:0]          issue_avail,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_run,
  output logic                      stall_timeout
);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0]     addr_q, addr_d;
  logic [DEPTH-1:0][SEL_W-1:0]      avail_q, avail_d;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]                 stall_run_q, stall_run_d;
  logic                             stall_timeout_q, stall_timeout_d;

  logic [NUM_SRC*SEL_W-1:0]         sel_res;
  logic [NUM_SRC-1:0]               hazard;
  logic [SEL_W-1:0]                 avail_clamped;
  logic                             accept;

  // Per-operand resolve: the youngest (lowest-index) matching writer decides.
  always_comb begin
    sel_res = '0;
    hazard  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin : g_res
      logic              found;
      logic [REG_AW-1:0] sa;
      found = 1'b0;
      sa    = src_addr[i*REG_AW +: REG_AW];
      if (src_used[i] && (sa != '0)) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!found && valid_q[k] && (addr_q[k] == sa)) begin
            found = 1'b1;
            // The retiring entry is covered by regfile write-before-read.
            if (k != DEPTH - 1) begin
              if ((k + 1) >= 32'(avail_q[k]))
                sel_res[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
              else
                hazard[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Stall request, issue acceptance and clamped result-availability index.
  always_comb begin
    stall  = issue_valid & ~flush & (|hazard);
    accept = issue_valid & ~flush & ~stall;
    if (issue_avail == '0)
      avail_clamped = SEL_W'(1);
    else if (32'(issue_avail) > DEPTH - 1)
      avail_clamped = SEL_W'(DEPTH - 1);
    else
      avail_clamped = issue_avail;
  end

  // Next state: scoreboard shift, forward selects, stall run-length and sticky timeout.
  always_comb begin
    valid_d         = valid_q;
    addr_d          = addr_q;
    avail_d         = avail_q;
    fwd_sel_d       = fwd_sel_q;
    stall_run_d     = stall_run_q;
    stall_timeout_d = stall_timeout_q | (stall_run_q == CNT_W'(STALL_LIMIT));

    if (advance) begin
      for (int unsigned k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
        avail_d[k] = avail_q[k-1];
      end
      if (accept) begin
        valid_d[0] = issue_wr_en & (issue_wr_addr != '0);
        addr_d[0]  = issue_wr_addr;
        avail_d[0] = avail_clamped;
        fwd_sel_d  = sel_res;
      end else begin
        valid_d[0] = 1'b0;
        addr_d[0]  = '0;
        avail_d[0] = SEL_W'(1);
        fwd_sel_d  = '0;
      end
    end

    // Stall counts even while frozen; only an advancing non-stall edge clears it.
    if (stall) begin
      if (stall_run_q != '1)
        stall_run_d = stall_run_q + CNT_W'(1);
    end else if (advance) begin
      stall_run_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q         <= '0;
      addr_q          <= '0;
      avail_q         <= '0;
      fwd_sel_q       <= '0;
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      addr_q          <= addr_d;
      avail_q         <= avail_d;
      fwd_sel_q       <= fwd_sel_d;
      stall_run_q     <= stall_run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign fwd_sel       = fwd_sel_q;
  assign stall_run     = stall_run_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: two instances (3-deep / 2 operands
// with a short stall limit, and 5-deep / 3 operands) share one stimulus bus;
// each cycle's expectation is queued and checked by a negedge monitor.
module tb_fwd_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance, flush, issue_valid, issue_wr_en;
  logic [4:0]  wr_addr;
  logic [2:0]  avail;
  logic [2:0]  used;
  logic [14:0] saddr;

  logic [3:0]  sel_a;
  logic        stall_a, to_a;
  logic [3:0]  run_a;
  logic [8:0]  sel_b;
  logic        stall_b, to_b;
  logic [3:0]  run_b;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int dut;
    int s0, s1, s2;
    int st;
    int run;
    int to;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fwd_scoreboard_unit #(
    .REG_AW(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(4), .STALL_LIMIT(3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_addr(wr_addr), .issue_avail(avail[1:0]),
    .src_used(used[1:0]), .src_addr(saddr[9:0]),
    .fwd_sel(sel_a), .stall(stall_a), .stall_run(run_a), .stall_timeout(to_a)
  );

  fwd_scoreboard_unit #(
    .REG_AW(5), .NUM_SRC(3), .DEPTH(5), .CNT_W(4), .STALL_LIMIT(12)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_addr(wr_addr), .issue_avail(avail),
    .src_used(used), .src_addr(saddr),
    .fwd_sel(sel_b), .stall(stall_b), .stall_run(run_b), .stall_timeout(to_b)
  );

  task automatic check(input string name, input int c, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, c, got, expv);
    end
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.dut == 0) begin
        logic [3:0] es;
        es = {e.s1[1:0], e.s0[1:0]};
        check("a_fwd_sel", e.cyc, int'(sel_a), int'(es));
        check("a_stall", e.cyc, int'(stall_a), e.st);
        check("a_stall_run", e.cyc, int'(run_a), e.run);
        check("a_timeout", e.cyc, int'(to_a), e.to);
      end else begin
        logic [8:0] es;
        es = {e.s2[2:0], e.s1[2:0], e.s0[2:0]};
        check("b_fwd_sel", e.cyc, int'(sel_b), int'(es));
        check("b_stall", e.cyc, int'(stall_b), e.st);
        check("b_stall_run", e.cyc, int'(run_b), e.run);
        check("b_timeout", e.cyc, int'(to_b), e.to);
      end
    end
  end

  task automatic push(input int d, input int e0, input int e1, input int e2,
                      input int est, input int erun, input int eto);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.s0 = e0; e.s1 = e1; e.s2 = e2;
    e.st = est; e.run = erun; e.to = eto;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs, queue the expected outputs (d=2: none), advance a clock.
  task automatic step(input bit adv, input bit fl, input bit iv, input bit we,
                      input int wa, input int av, input int u,
                      input int a0, input int a1, input int a2,
                      input int d, input int e0, input int e1, input int e2,
                      input int est, input int erun, input int eto);
    advance     = adv;
    flush       = fl;
    issue_valid = iv;
    issue_wr_en = we;
    wr_addr     = 5'(wa);
    avail       = 3'(av);
    used        = 3'(u);
    saddr       = {5'(a2), 5'(a1), 5'(a0)};
    if (d != 2) push(d, e0, e1, e2, est, erun, eto);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    advance = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_wr_en = 1'b0;
    wr_addr = '0; avail = '0; used = '0; saddr = '0;
    @(posedge clk);
    #1;
    // Reset state of both instances
    push(1, 0, 0, 0, 0, 0, 0);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0,0,0);
    rst_n = 1'b1;

    // ALU producer -> immediate consumer, both operands forward from entry 1
    step(1,0,1,1, 8,1,0, 0,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,1,1, 9,1,3, 8,8,0, 0, 0,0,0, 0,0,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 1,1,0, 0,0,0);
    // Load-use: one stall, bubble in EX, then sel=2 for op0 only
    step(1,0,1,1, 8,2,0, 0,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,1,1,10,1,3, 8,1,0, 0, 0,0,0, 1,0,0);
    step(1,0,1,1,10,1,3, 8,1,0, 0, 0,0,0, 0,1,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 2,0,0, 0,0,0);
    // Two writers of r8, r0 destination; youngest wins, r0 never forwards
    step(1,0,1,1, 8,1,0, 0,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,1,1, 8,1,0, 0,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,1,1, 0,1,3, 8,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,1,0, 0,0,3, 0,8,0, 0, 1,0,0, 0,0,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 0,2,0, 0,0,0);
    // Frozen load-use hazard: stall held, run counts, timeout at limit 3
    step(1,0,1,1, 5,2,0, 0,0,0, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 6,1,3, 5,5,0, 0, 0,0,0, 1,0,0);
    step(0,0,1,1, 6,1,3, 5,5,0, 0, 0,0,0, 1,1,0);
    step(0,0,1,1, 6,1,3, 5,5,0, 0, 0,0,0, 1,2,0);
    step(1,0,1,1, 6,1,3, 5,5,0, 0, 0,0,0, 1,3,0);
    step(1,0,1,1, 6,1,3, 5,5,0, 0, 0,0,0, 0,4,1);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 2,2,0, 0,0,1);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0,0,1);
    // Flush during a hazard: no stall, bubble enters, older entry still shifts
    step(1,0,1,1, 7,2,0, 0,0,0, 0, 0,0,0, 0,0,1);
    step(1,1,1,1,11,1,1, 7,0,0, 0, 0,0,0, 0,0,1);
    step(1,0,1,1,11,1,1, 7,0,0, 0, 0,0,0, 0,0,1);
    // Reset mid-sequence clears selects, scoreboard and sticky timeout
    rst_n = 1'b0;
    step(1,0,1,0, 0,0,1,11,0,0, 0, 2,0,0, 0,0,1);
    rst_n = 1'b1;
    step(1,0,1,0, 0,0,1,11,0,0, 0, 0,0,0, 0,0,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0,0,0);

    // Deep instance: fresh reset
    rst_n = 1'b0;
    step(1,0,0,0, 0,0,0, 0,0,0, 2, 0,0,0, 0,0,0);
    rst_n = 1'b1;
    // avail=4 producer, consumer behind it: 3 stalls then sel=4 on ops 0 and 2
    step(1,0,1,1,12,4,0, 0,0,0, 1, 0,0,0, 0,0,0);
    step(1,0,1,1,13,1,7,12,3,12, 1, 0,0,0, 1,0,0);
    step(1,0,1,1,13,1,7,12,3,12, 1, 0,0,0, 1,1,0);
    step(1,0,1,1,13,1,7,12,3,12, 1, 0,0,0, 1,2,0);
    step(1,0,1,1,13,1,7,12,3,12, 1, 0,0,0, 0,3,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 1, 4,0,4, 0,0,0);
    // avail=7 clamps to 4: same 3 stalls, then sel=4 on op2
    step(1,0,1,1,15,7,0, 0,0,0, 1, 0,0,0, 0,0,0);
    step(1,0,1,1,16,1,5, 0,0,15, 1, 0,0,0, 1,0,0);
    step(1,0,1,1,16,1,5, 0,0,15, 1, 0,0,0, 1,1,0);
    step(1,0,1,1,16,1,5, 0,0,15, 1, 0,0,0, 1,2,0);
    step(1,0,1,1,16,1,5, 0,0,15, 1, 0,0,0, 0,3,0);
    step(1,0,0,0, 0,0,0, 0,0,0, 1, 0,0,4, 0,0,0);

    // Drain with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
